// File: rtl/multiword_add_seq.sv
// Wide add/subtract: one shared 16-bit adder walks the operands one chunk per clock, rippling carry between chunks.
// Latency: out_valid rises exactly WORDS clocks after the accepting edge; one operation in flight at a time.
// Backpressure: in_ready only in IDLE; the result is held stable in DONE for as long as out_ready stays low.

module adder_16 (
   input  logic [15:0] a_i,
   input  logic [15:0] b_i,
   input  logic        c_i,
   output logic [15:0] s_o,
   output logic        c_o
);
   // Plain 16-bit ripple add with carry in and carry out.
   assign {c_o, s_o} = {1'b0, a_i} + {1'b0, b_i} + {16'd0, c_i};
endmodule

module multiword_add_seq #(
   parameter int WORDS = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [16*WORDS-1:0] in_a,
   input  logic [16*WORDS-1:0] in_b,
   input  logic                in_sub,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [16*WORDS-1:0] out_sum,
   output logic                out_cout,
   output logic                out_ovf
);
   localparam int W  = 16 * WORDS;
   localparam int CW = $clog2(WORDS);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          carry_q, carry_d;
   logic [W-1:0]  a_q, a_d;
   logic [W-1:0]  b_q, b_d;
   logic [W-1:0]  sum_q, sum_d;
   logic          cout_q, cout_d;
   logic          ovf_q, ovf_d;

   logic [15:0]   a_chunk, b_chunk, add_s;
   logic          add_co;
   logic          last_chunk;

   assign in_ready   = (state_q == S_IDLE);
   assign out_valid  = (state_q == S_DONE);
   assign out_sum    = sum_q;
   assign out_cout   = cout_q;
   assign out_ovf    = ovf_q;
   assign last_chunk = (cnt_q == CW'(WORDS - 1));

   // Select the operand chunk addressed by the chunk counter.
   always_comb begin
      a_chunk = 16'd0;
      b_chunk = 16'd0;
      for (int i = 0; i < WORDS; i++) begin
         if (cnt_q == CW'(i)) begin
            a_chunk = a_q[16*i +: 16];
            b_chunk = b_q[16*i +: 16];
         end
      end
   end

   adder_16 u_adder (
      .a_i (a_chunk),
      .b_i (b_chunk),
      .c_i (carry_q),
      .s_o (add_s),
      .c_o (add_co)
   );

   // Next-state logic: accept in IDLE, one chunk per cycle in RUN, hold result in DONE.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               // Subtract is A + ~B + 1: invert B here and seed the carry with 1.
               a_d     = in_a;
               b_d     = in_b ^ {W{in_sub}};
               carry_d = in_sub;
               cnt_d   = '0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            for (int i = 0; i < WORDS; i++) begin
               if (cnt_q == CW'(i)) begin
                  sum_d[16*i +: 16] = add_s;
               end
            end
            carry_d = add_co;
            if (last_chunk) begin
               cout_d  = add_co;
               ovf_d   = (a_q[W-1] == b_q[W-1]) & (add_s[15] != a_q[W-1]);
               cnt_d   = '0;
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_DONE: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State registers; reset drops any operation in progress.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end
endmodule

// File: tb/tb_multiword_add_seq.sv
// Bench for multiword_add_seq (WORDS=4): directed vectors with literal expectations,
// plus a per-cycle monitor comparing handshakes and results against a plain-arithmetic model.
// Inputs change 1ns after the rising edge; the monitor samples on the falling edge.

module tb_multiword_add_seq;
   localparam int WORDS = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [63:0] in_a = '0;
   logic [63:0] in_b = '0;
   logic        in_sub = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [63:0] out_sum;
   logic        out_cout;
   logic        out_ovf;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   // Model state: at most one operation in flight.
   bit          busy = 1'b0;
   logic [65:0] exp_res;
   int          exp_e = 0;

   multiword_add_seq #(.WORDS(WORDS)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_sub    (in_sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_cout  (out_cout),
      .out_ovf   (out_ovf)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", nm, act, req);
      end
   endtask

   // Returns {ovf, cout, sum} from ordinary wide arithmetic.
   function automatic logic [65:0] model(input logic [63:0] a, input logic [63:0] b, input logic sub);
      logic [64:0] full;
      logic        ovf;
      if (sub) begin
         full = {1'b0, a} + {1'b0, ~b} + 65'd1;
         ovf  = (a[63] != b[63]) && (full[63] != a[63]);
      end else begin
         full = {1'b0, a} + {1'b0, b};
         ovf  = (a[63] == b[63]) && (full[63] != a[63]);
      end
      return {ovf, full};
   endfunction

   // Per-cycle monitor: handshake outputs and, when valid, the result.
   always @(negedge clk) begin
      if (!rst_n) begin
         busy = 1'b0;
         chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
         chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
         chk("rst_out_sum", out_sum, 64'd0);
      end else begin
         chk("mon_out_valid", {63'd0, out_valid}, {63'd0, busy && (cyc >= exp_e + WORDS)});
         chk("mon_in_ready", {63'd0, in_ready}, {63'd0, !busy});
         if (out_valid && busy) begin
            chk("mon_sum", out_sum, exp_res[63:0]);
            chk("mon_cout", {63'd0, out_cout}, {63'd0, exp_res[64]});
            chk("mon_ovf", {63'd0, out_ovf}, {63'd0, exp_res[65]});
         end
         if (out_valid && out_ready) busy = 1'b0;
         if (in_valid && in_ready) begin
            busy    = 1'b1;
            exp_res = model(in_a, in_b, in_sub);
            exp_e   = cyc + 1;
         end
      end
   end

   // One operation: accept, measure latency, check literals, optional hold with the next request pending.
   task automatic do_op(input logic [63:0] a, input logic [63:0] b, input logic s,
                        input logic [63:0] es, input logic ec, input logic eo,
                        input int hold, input bit preload,
                        input logic [63:0] na, input logic [63:0] nb, input logic ns);
      int n;
      in_a = a; in_b = b; in_sub = s; in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 50) begin
         @(posedge clk); #1; n++;
      end
      chk("accept_wait", {63'd0, in_ready}, 64'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_a = {$urandom, $urandom};
      in_b = {$urandom, $urandom};
      in_sub = 1'($urandom);
      n = 0;
      while (!out_valid && n < 50) begin
         @(posedge clk); #1; n++;
      end
      chk("latency", 64'(n), 64'd4);
      chk("sum", out_sum, es);
      chk("cout", {63'd0, out_cout}, {63'd0, ec});
      chk("ovf", {63'd0, out_ovf}, {63'd0, eo});
      if (preload) begin
         in_a = na; in_b = nb; in_sub = ns; in_valid = 1'b1;
      end
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         chk("hold_in_ready", {63'd0, in_ready}, 64'd0);
         chk("hold_out_valid", {63'd0, out_valid}, 64'd1);
         chk("hold_sum", out_sum, es);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("post_in_ready", {63'd0, in_ready}, 64'd1);
      chk("post_out_valid", {63'd0, out_valid}, 64'd0);
   endtask

   initial begin
      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      chk("init_in_ready", {63'd0, in_ready}, 64'd1);
      chk("init_out_valid", {63'd0, out_valid}, 64'd0);
      chk("init_out_sum", out_sum, 64'd0);

      do_op(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 64'h0000_0000_0001_0000, 1'b0, 1'b0, 0, 1'b0, '0, '0, 1'b0);
      do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0, 1'b1, 1'b0, 0, 1'b0, '0, '0, 1'b0);
      do_op(64'h0, 64'h1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 0, 1'b0, '0, '0, 1'b0);
      do_op(64'h5, 64'h3, 1'b1, 64'h2, 1'b1, 1'b0, 0, 1'b0, '0, '0, 1'b0);
      do_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 0, 1'b0, '0, '0, 1'b0);
      do_op(64'h8000_0000_0000_0000, 64'h1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 0, 1'b0, '0, '0, 1'b0);

      // Backpressure: result held 6 cycles while a new request waits, then the waiting request runs.
      do_op(64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b0, 64'h1234_5678_9ABC_DF00, 1'b0, 1'b0,
            6, 1'b1, 64'h0000_0000_0001_0000, 64'h1, 1'b1);
      do_op(64'h0000_0000_0001_0000, 64'h1, 1'b1, 64'h0000_0000_0000_FFFF, 1'b1, 1'b0, 0, 1'b0, '0, '0, 1'b0);

      // Reset two cycles into RUN abandons the operation at once.
      in_a = 64'h1111_2222_3333_4444; in_b = 64'h0001_0001_0001_0001; in_sub = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("pre_rst_sum_low", {32'd0, out_sum[31:0]}, 64'h0000_0000_3334_4445);
      rst_n = 1'b0;
      #1;
      chk("async_in_ready", {63'd0, in_ready}, 64'd1);
      chk("async_out_valid", {63'd0, out_valid}, 64'd0);
      chk("async_out_sum", out_sum, 64'd0);
      chk("async_cout", {63'd0, out_cout}, 64'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      do_op(64'h1234, 64'h1, 1'b0, 64'h1235, 1'b0, 1'b0, 0, 1'b0, '0, '0, 1'b0);

      repeat (3) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
